// File: rtl/vga_frame_pipeline_if.sv
// vga_frame_pipeline_if: pixel write port and clear control between drawing logic and the frame pipeline
interface vga_frame_pipeline_if;
  logic       wrValid;
  logic [7:0] wrX;
  logic [6:0] wrY;
  logic [2:0] wrColor;
  logic       wrReady;
  logic       clearReq;
  logic [2:0] clearColor;
  logic       clearBusy;
  modport master (output wrValid, wrX, wrY, wrColor, clearReq, clearColor, input wrReady, clearBusy);
  modport slave (input wrValid, wrX, wrY, wrColor, clearReq, clearColor, output wrReady, clearBusy);
endinterface

// File: rtl/vga_frame_pipeline.sv
// vga_frame_pipeline: 160x120x3 frame buffer scanned out 4x upscaled through a 3-strobe pipeline.
// Optional fill engine built when VGA_FB_CLEAR_EN is defined.
module vga_frame_pipeline #(
  parameter int FB_W = 160,
  parameter int FB_H = 120,
  parameter int SCALE_LOG2 = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pixelEn,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       hsyncIn,
  input  logic       vsyncIn,
  input  logic       blankIn_b,
  vga_frame_pipeline_if.slave wr,
  output logic       hsync,
  output logic       vsync,
  output logic       blank_b,
  output logic [3:0] vgaR,
  output logic [3:0] vgaG,
  output logic [3:0] vgaB
);
  localparam int DEPTH = FB_W * FB_H;
  localparam int AW = 15;
  logic [2:0] mem [DEPTH];
  logic s1_hs, s1_vs, s1_bl, s2_hs, s2_vs, s2_bl;
  logic [AW-1:0] s1_addr, wr_addr, mem_addr, clr_cnt;
  logic [2:0] s2_pix, mem_data, clr_color;
  logic wr_in_range, mem_we, clr_we;
`ifdef VGA_FB_CLEAR_EN
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state, state_nx;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      clr_cnt <= '0;
      clr_color <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && wr.clearReq) begin
        clr_cnt <= '0;
        clr_color <= wr.clearColor;
      end else if (clr_we) clr_cnt <= clr_cnt + AW'(1);
    end
  always_comb
    state_nx = (state == IDLE) ? (wr.clearReq ? CLEAR : IDLE)
             : (clr_we && clr_cnt == AW'(DEPTH - 1)) ? IDLE : CLEAR;
  always_comb begin
    wr.clearBusy = (state == CLEAR);
    clr_we = (state == CLEAR) && !pixelEn;
  end
`else
  logic unused_clear;
  assign unused_clear = ^{wr.clearReq, wr.clearColor};
  assign wr.clearBusy = 1'b0;
  assign clr_we = 1'b0;
  assign clr_cnt = '0;
  assign clr_color = '0;
`endif
  assign wr.wrReady = ~pixelEn & ~wr.clearBusy;
  assign wr_addr = AW'(int'(wr.wrY) * FB_W + int'(wr.wrX));
  assign wr_in_range = (int'(wr.wrX) < FB_W) && (int'(wr.wrY) < FB_H);
  assign mem_we = clr_we | (wr.wrValid & wr.wrReady & wr_in_range);
  assign mem_addr = clr_we ? clr_cnt : wr_addr;
  assign mem_data = clr_we ? clr_color : wr.wrColor;
  // single port: display read owns strobe cycles, writes and fill take the gaps
  always_ff @(posedge clk)
    if (pixelEn) s2_pix <= mem[s1_addr];
    else if (mem_we) mem[mem_addr] <= mem_data;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      {s1_hs, s1_vs, s1_bl} <= 3'b110;
      s1_addr <= '0;
      {s2_hs, s2_vs, s2_bl} <= 3'b110;
      {hsync, vsync, blank_b} <= 3'b110;
      {vgaR, vgaG, vgaB} <= '0;
    end else if (pixelEn) begin
      {s1_hs, s1_vs, s1_bl} <= {hsyncIn, vsyncIn, blankIn_b};
      s1_addr <= blankIn_b ? AW'((int'(y) >> SCALE_LOG2) * FB_W + (int'(x) >> SCALE_LOG2)) : '0;
      {s2_hs, s2_vs, s2_bl} <= {s1_hs, s1_vs, s1_bl};
      {hsync, vsync, blank_b} <= {s2_hs, s2_vs, s2_bl};
      vgaR <= s2_bl ? {4{s2_pix[2]}} : 4'h0;
      vgaG <= s2_bl ? {4{s2_pix[1]}} : 4'h0;
      vgaB <= s2_bl ? {4{s2_pix[0]}} : 4'h0;
    end
endmodule

// File: tb/tb_vga_frame_pipeline.sv
// tb_vga_frame_pipeline: directed plus randomized scan-out checks against a frame/pipeline reference model
module tb_vga_frame_pipeline;
  logic clk = 1'b0;
  logic reset, pixelEn, hsyncIn, vsyncIn, blankIn_b;
  logic [9:0] x, y;
  logic hsync, vsync, blank_b;
  logic [3:0] vgaR, vgaG, vgaB;
  vga_frame_pipeline_if wr();
  vga_frame_pipeline dut (
    .clk(clk), .reset(reset), .pixelEn(pixelEn), .x(x), .y(y),
    .hsyncIn(hsyncIn), .vsyncIn(vsyncIn), .blankIn_b(blankIn_b), .wr(wr),
    .hsync(hsync), .vsync(vsync), .blank_b(blank_b), .vgaR(vgaR), .vgaG(vgaG), .vgaB(vgaB)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic hs, vs, bl;
    logic [14:0] idx;
    logic [2:0] pix;
  } ent_t;
  localparam ent_t RST_E = '{hs: 1'b1, vs: 1'b1, bl: 1'b0, idx: 15'd0, pix: 3'd0};
  logic [2:0] fb [19200];
  ent_t e1, e2, last_out;
  int n_asserts = 0, n_fails = 0;
  wire [14:0] dut_out = {hsync, vsync, blank_b, vgaR, vgaG, vgaB};
  function automatic logic [14:0] outv(ent_t e);
    return {e.hs, e.vs, e.bl, e.bl ? {4{e.pix[2]}} : 4'h0, e.bl ? {4{e.pix[1]}} : 4'h0, e.bl ? {4{e.pix[0]}} : 4'h0};
  endfunction
  task automatic chk(string tag, logic [15:0] obs, logic [15:0] expv);
    n_asserts++;
    assert (obs === expv) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask
  task automatic model_reset();
    e1 = RST_E;
    e2 = RST_E;
    last_out = RST_E;
  endtask
  // one display strobe; checks the entry that entered two strobes earlier
  task automatic pe(input logic [9:0] xx, input logic [9:0] yy, input logic hs, input logic vs, input logic bl);
    ent_t n;
    pixelEn = 1'b1; x = xx; y = yy; hsyncIn = hs; vsyncIn = vs; blankIn_b = bl;
    if (wr.wrValid) begin
      #1 chk("wrready_on_strobe", wr.wrReady, 0);
    end
    @(posedge clk);
    n = '{hs: hs, vs: vs, bl: bl, idx: 15'((yy / 4) * 160 + xx / 4), pix: 3'd0};
    last_out = e2;
    e2 = e1;
    if (e2.bl) e2.pix = fb[e2.idx];
    e1 = n;
    #1 chk("pipe_out", dut_out, outv(last_out));
  endtask
  task automatic idle(input logic cr, input logic [2:0] cc);
    pixelEn = 1'b0; wr.clearReq = cr; wr.clearColor = cc;
    @(posedge clk);
    #1 chk("out_hold", dut_out, outv(last_out));
    wr.clearReq = 1'b0;
  endtask
  task automatic wr_px(input logic [7:0] wx, input logic [6:0] wy, input logic [2:0] c);
    pixelEn = 1'b0; wr.wrValid = 1'b1; wr.wrX = wx; wr.wrY = wy; wr.wrColor = c;
    #1 chk("wrready_idle", wr.wrReady, 1);
    @(posedge clk);
    if (wx < 160 && wy < 120) fb[int'(wy) * 160 + int'(wx)] = c;
    #1 wr.wrValid = 1'b0;
  endtask
  task automatic rd(input int col, input int row);
    pe(10'(col * 4 + $urandom_range(3, 0)), 10'(row * 4 + $urandom_range(3, 0)), 1'b1, 1'b1, 1'b1);
    idle(1'b0, 3'd0);
  endtask
  task automatic flush();
    repeat (2) begin
      pe(10'd0, 10'd0, 1'b1, 1'b1, 1'b0);
      idle(1'b0, 3'd0);
    end
  endtask
  initial begin
    int cnt;
    logic [2:0] c;
    reset = 1'b1; pixelEn = 1'b0; x = '0; y = '0; hsyncIn = 1'b1; vsyncIn = 1'b1; blankIn_b = 1'b0;
    wr.wrValid = 1'b0; wr.wrX = '0; wr.wrY = '0; wr.wrColor = '0; wr.clearReq = 1'b0; wr.clearColor = '0;
    model_reset();
    #2 chk("reset_out", dut_out, 15'h6000);
    chk("reset_busy", wr.clearBusy, 0);
    @(posedge clk);
    #3 reset = 1'b0;
    // known content for buffer rows 0..15
    for (int r = 0; r < 16; r++)
      for (int col = 0; col < 160; col++) begin
        c = 3'($urandom_range(7, 0));
        if (col >= 4 && col <= 6 && r >= 2 && r <= 4) c = 3'b011;
        if (r == 10) c = 3'($urandom_range(6, 0));
        if (r == 1 && col == 0) c = 3'b001;
        wr_px(8'(col), 7'(r), c);
      end
    // single pixel write, then its 4x4 screen block and neighbours
    wr_px(8'd5, 7'd3, 3'b101);
    for (int yy = 12; yy < 16; yy++)
      for (int xx = 20; xx < 24; xx++) begin
        pe(10'(xx), 10'(yy), 1'b1, 1'b1, 1'b1);
        idle(1'b0, 3'd0);
      end
    flush();
    chk("px_5_3", dut_out, 15'h7F0F);
    rd(4, 3); rd(6, 3); rd(5, 2); rd(5, 4);
    flush();
    // write held across strobes: only gap cycles land, the strobe-cycle decoy must not
    for (int i = 0; i < 16; i++) begin
      wr.wrValid = 1'b1; wr.wrX = 8'(40 + i); wr.wrY = 7'd10; wr.wrColor = 3'd7;
      pe(10'd0, 10'd0, 1'b1, 1'b1, 1'b0);
      wr_px(8'(40 + i), 7'd11, 3'($urandom_range(7, 0)));
    end
    for (int i = 0; i < 16; i++) begin
      rd(40 + i, 10);
      rd(40 + i, 11);
    end
    flush();
    // out-of-range writes are consumed but discarded
    wr_px(8'd160, 7'd0, 3'd7);
    wr_px(8'd0, 7'd120, 3'd7);
    rd(0, 1); rd(0, 0);
    flush();
    // random sync/blank/coordinate traffic over known rows
    for (int i = 0; i < 300; i++) begin
      pe(10'($urandom_range(639, 0)), 10'($urandom_range(63, 0)), 1'($urandom), 1'($urandom), 1'($urandom));
      idle(1'b0, 3'd0);
    end
    // asynchronous reset mid-frame
    repeat (3) pe(10'd100, 10'd20, 1'b0, 1'b0, 1'b1);
    #3 reset = 1'b1;
    #1 chk("reset_mid_out", dut_out, 15'h6000);
    chk("reset_mid_busy", wr.clearBusy, 0);
    model_reset();
    @(posedge clk);
    #3 reset = 1'b0;
    rd(7, 7); rd(8, 8);
    flush();
`ifdef VGA_FB_CLEAR_EN
    idle(1'b1, 3'b010);
    chk("clear_busy_rise", wr.clearBusy, 1);
    cnt = 0;
    for (int it = 0; it < 20000 && wr.clearBusy; it++) begin
      pe(10'd0, 10'd0, 1'b1, 1'b1, 1'b0);
      pixelEn = 1'b0;
      if (it == 7000) begin
        wr.wrValid = 1'b1; wr.wrX = 8'd0; wr.wrY = 8'd0; wr.wrColor = 3'd7;
        #1 chk("wrready_busy", wr.wrReady, 0);
      end
      if (wr.clearBusy) cnt++;
      idle(it == 5000, 3'b100);
      wr.wrValid = 1'b0;
    end
    chk("clear_len", 16'(cnt), 16'd19200);
    chk("clear_busy_fall", wr.clearBusy, 0);
    for (int i = 0; i < 19200; i++) fb[i] = 3'b010;
    for (int i = 0; i < 300; i++) begin
      pe(10'($urandom_range(639, 0)), 10'($urandom_range(479, 0)), 1'b1, 1'b1, 1'b1);
      idle(1'b0, 3'd0);
    end
    flush();
`else
    idle(1'b1, 3'b010);
    chk("noclear_busy", wr.clearBusy, 0);
    pixelEn = 1'b0;
    #1 chk("noclear_ready", wr.wrReady, 1);
    rd(5, 3);
    flush();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end
endmodule

// File: doc/vga_frame_pipeline.md
# vga_frame_pipeline

Display-side pixel stage placed directly downstream of the VGA timing controller. Holds a 160x120, 3-bit-per-pixel frame buffer, maps each 640x480 screen coordinate from the controller onto it (4x4 pixel replication), and emits registered RGB with hsync/vsync/blank delayed to match the read latency. A valid/ready write port lets drawing logic update pixels between display reads. An optional clear engine fills the buffer with one colour.

## Interface
Parameters:
- FB_W, 160, frame-buffer width in pixels
- FB_H, 120, frame-buffer height in pixels
- SCALE_LOG2, 2, log2 of screen-to-buffer scale (screen pixels per buffer pixel per axis)

Ports:
- clk  in  1  system clock, 2x pixel rate; one clock for the whole block
- reset  in  1  asynchronous, active-high
- pixelEn  in  1  one-cycle strobe per pixel, every other clk; marks cycles where x/y/hsync/vsync/blank_b are valid
- x  in  10  screen column from the timing controller
- y  in  10  screen row from the timing controller
- hsyncIn, vsyncIn  in  1 each  active-low syncs from the timing controller
- blankIn_b  in  1  high while in the visible region
- wrValid  in  1  write request
- wrX  in  8  buffer column
- wrY  in  7  buffer row
- wrColor  in  3  {r,g,b} pixel value
- wrReady  out  1  write accepted this cycle when wrValid & wrReady
- clearReq  in  1  one-cycle pulse that starts a full-buffer fill
- clearColor  in  3  fill value, sampled with clearReq
- clearBusy  out  1  high while the fill runs
- hsync, vsync  out  1 each  delayed active-low syncs
- blank_b  out  1  delayed visible flag
- vgaR, vgaG, vgaB  out  4 each  colour outputs

## Operation
- Pipeline advances only on cycles with pixelEn=1. It has three stages:
- S1 registers sync/blank and the read address. Address = (y>>SCALE_LOG2)*FB_W + (x>>SCALE_LOG2). It is forced to 0 when blankIn_b=0. The address is 15 bits wide; the multiply is by a constant.
- S2 registers the synchronous RAM read data and the S1 sync/blank.
- S3 registers the outputs. vgaR={4{pix[2]}}, vgaG={4{pix[1]}}, vgaB={4{pix[0]}}. All colours are 0 when the S2 blank_b=0.
- RAM is single-port, FB_W*FB_H x 3. The display read owns the port on pixelEn=1 cycles.
- wrReady = ~pixelEn & ~clearBusy. Accepted writes go to address wrY*FB_W+wrX.
- An accepted write with wrX>=FB_W or wrY>=FB_H is consumed and discarded; RAM is unchanged.
- Clear FSM has two states:
  - IDLE: on clearReq, latch clearColor, set the counter to 0, go to CLEAR.
  - CLEAR: on each pixelEn=0 cycle, write the latched colour at the counter and increment it. After writing FB_W*FB_H-1, return to IDLE.
- clearReq in CLEAR is ignored. A write and a clear word never occur in the same cycle, because wrReady=0 during CLEAR.
- Display reads continue during CLEAR and show mixed old/new content. This is allowed.

## Timing
- Latency is 3 pixelEn strobes: inputs sampled at strobe n appear on the outputs after strobe n+2's clock edge. They are held for 2 clk.
- A write accepted at clk edge k is visible to a display read at any later pixelEn edge.
- Clear takes exactly 19200 pixelEn=0 cycles, about 38400 clk.
- clearBusy rises on the edge after clearReq and falls on the edge after the last clear write.
- Values on reset assertion, applied immediately because reset is asynchronous:
  - hsync=1, vsync=1, blank_b=0, vgaR/G/B=0
  - clearBusy=0, FSM=IDLE
  - all pipeline registers: syncs=1, blank=0
- Reset mid-clear aborts the fill; RAM is left partially written.
- RAM contents are not reset.
- x=639 to 0 and y wrap need no special handling. The address depends only on the current inputs.

## Configuration
- VGA_FB_CLEAR_EN defined: clear FSM, counter and clearColor latch are built as described.
- VGA_FB_CLEAR_EN undefined: no clear logic. clearReq and clearColor are ignored, clearBusy is tied 0, and wrReady = ~pixelEn.

## Test plan
- Write wrX=5, wrY=3, wrColor=3'b101 with pixelEn=0. Then drive x=20..23, y=12..15 with blank_b=1. Required: vgaR=4'hF, vgaG=0, vgaB=4'hF three strobes later; neighbouring pixels show prior contents.
- Hold wrValid=1 across alternating pixelEn. Required: wrReady=0 on every pixelEn=1 cycle, and exactly one write lands per pixelEn=0 cycle.
- Write wrX=160, wrY=0 with colour 7. Required: accepted with wrReady=1; address 160 (x=0,y=1) is unchanged.
- Send clearReq with clearColor=3'b010, then pulse clearReq again mid-fill. Required: clearBusy stays high for 19200 pixelEn=0 cycles, the second pulse is ignored, and a full frame then reads vgaG=4'hF only.
- Drive a hsyncIn/blankIn_b edge at strobe n. Required: the output edge appears after strobe n+2. Also assert reset mid-frame. Required: outputs go immediately to hsync=vsync=1, blank_b=0, colours 0.
